// File: rtl/memory_arbiter.sv
// Shares one variable-latency memory port between the instruction and data masters, round-robin on contention.
// Latency is 2 cycles plus memory wait states; a requester sees no ready until its access completes or the watchdog aborts it.
module memory_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instruction_memory_interface_enable,
  input  logic        instruction_memory_interface_state,
  input  logic [31:0] instruction_memory_interface_address,
  input  logic [3:0]  instruction_memory_interface_frame_mask,
  output logic [31:0] instruction_memory_interface_data,
  output logic        instruction_memory_interface_ready,
  input  logic        data_memory_interface_enable,
  input  logic        data_memory_interface_state,
  input  logic [31:0] data_memory_interface_address,
  input  logic [3:0]  data_memory_interface_frame_mask,
  input  logic [31:0] data_memory_interface_write_data,
  output logic [31:0] data_memory_interface_read_data,
  output logic        data_memory_interface_ready,
  output logic        bus_error,
  output logic        memory_request,
  output logic        memory_write,
  output logic [31:0] memory_address,
  output logic [3:0]  memory_frame_mask,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data,
  input  logic        memory_acknowledge
);

  localparam logic WRITE  = 1'b1;
  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;
  localparam int   CW     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_grant;
  logic          r_side;
  logic          r_write;
  logic          r_err;
  logic [31:0]   r_addr;
  logic [3:0]    r_mask;
  logic [31:0]   r_wdata;
  logic [31:0]   r_idata;
  logic [31:0]   r_ddata;
  logic [CW-1:0] r_cnt;
  logic          w_grant;
  logic          w_grant_side;
  logic          w_ack;
  logic          w_abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_grant_side = r_side;
    w_ack        = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (instruction_memory_interface_enable || data_memory_interface_enable) begin
          w_grant = 1'b1;
          if (instruction_memory_interface_enable && data_memory_interface_enable)
            w_grant_side = ~r_last_grant;
          else
            w_grant_side = data_memory_interface_enable;
          w_next = BUSY;
        end
      end
      BUSY: begin
        // An acknowledge arriving in the timeout cycle still completes the access cleanly.
        if (memory_acknowledge) begin
          w_ack  = 1'b1;
          w_next = RESPOND;
        end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == LIMIT)) begin
          w_abort = 1'b1;
          w_next  = RESPOND;
        end
      end
      RESPOND: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= SIDE_D;
      r_side       <= SIDE_I;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_mask       <= '0;
      r_wdata      <= '0;
    end else if (w_grant) begin
      r_side       <= w_grant_side;
      r_last_grant <= w_grant_side;
      if (w_grant_side == SIDE_D) begin
        r_write <= (data_memory_interface_state == WRITE);
        r_addr  <= data_memory_interface_address;
        r_mask  <= data_memory_interface_frame_mask;
        r_wdata <= data_memory_interface_write_data;
      end else begin
        r_write <= (instruction_memory_interface_state == WRITE);
        r_addr  <= instruction_memory_interface_address;
        r_mask  <= instruction_memory_interface_frame_mask;
        r_wdata <= '0;
      end
    end
  end

  // Read registers only change on a read completing (or aborting) on their own side.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idata <= '0;
      r_ddata <= '0;
    end else if ((w_ack || w_abort) && !r_write) begin
      if (r_side == SIDE_D) r_ddata <= w_ack ? memory_read_data : '0;
      else                  r_idata <= w_ack ? memory_read_data : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_abort)
        r_err <= 1'b1;
      else if (r_state == RESPOND)
        r_err <= 1'b0;

      if (r_state == RESPOND)
        r_cnt <= '0;
      else if ((r_state == BUSY) && !memory_acknowledge && (r_cnt != {CW{1'b1}}))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign memory_request    = (r_state == BUSY);
  assign memory_write      = r_write;
  assign memory_address    = r_addr;
  assign memory_frame_mask = r_mask;
  assign memory_write_data = r_wdata;

  assign instruction_memory_interface_data  = r_idata;
  assign data_memory_interface_read_data    = r_ddata;
  assign instruction_memory_interface_ready = (r_state == RESPOND) && (r_side == SIDE_I);
  assign data_memory_interface_ready        = (r_state == RESPOND) && (r_side == SIDE_D);
  assign bus_error                          = (r_state == RESPOND) && r_err;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised scoreboard bench for memory_arbiter with a behavioural memory responder.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_en, i_st, i_rdy;
  logic [31:0] i_addr, i_data;
  logic [3:0]  i_mask;
  logic        d_en, d_st, d_rdy;
  logic [31:0] d_addr, d_wd, d_rd;
  logic [3:0]  d_mask;
  logic        bus_error, mreq, mwr, mack;
  logic [31:0] maddr, mwd, mrd;
  logic [3:0]  mmask;

  always #5 clk = ~clk;

  memory_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                                    (clk),
    .reset                                  (reset),
    .instruction_memory_interface_enable    (i_en),
    .instruction_memory_interface_state     (i_st),
    .instruction_memory_interface_address   (i_addr),
    .instruction_memory_interface_frame_mask(i_mask),
    .instruction_memory_interface_data      (i_data),
    .instruction_memory_interface_ready     (i_rdy),
    .data_memory_interface_enable           (d_en),
    .data_memory_interface_state            (d_st),
    .data_memory_interface_address          (d_addr),
    .data_memory_interface_frame_mask       (d_mask),
    .data_memory_interface_write_data       (d_wd),
    .data_memory_interface_read_data        (d_rd),
    .data_memory_interface_ready            (d_rdy),
    .bus_error                              (bus_error),
    .memory_request                         (mreq),
    .memory_write                           (mwr),
    .memory_address                         (maddr),
    .memory_frame_mask                      (mmask),
    .memory_write_data                      (mwd),
    .memory_read_data                       (mrd),
    .memory_acknowledge                     (mack)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          ncyc;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        exp_i[$];
  exp_t        exp_d[$];
  int          order_q[$];
  int          ord_cyc[$];
  logic [31:0] model_rd[2];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ack_wait = 0;

  // Responder state: what the memory saw during the most recent access.
  int          n_req = 0;
  bit          prev_req = 1'b0;
  bit          unstable = 1'b0;
  bit          cap_wr;
  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_mask;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0051_0513;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Memory model: acks after ack_wait request cycles (negative = never); random ack noise while idle.
  always @(negedge clk) begin
    if (mreq) begin
      if (!prev_req) begin
        n_req    = 0;
        unstable = 1'b0;
        cap_wr   = mwr;
        cap_addr = maddr;
        cap_mask = mmask;
        cap_wd   = mwd;
      end else if ({cap_wr, cap_addr, cap_mask, cap_wd} !== {mwr, maddr, mmask, mwd}) begin
        unstable = 1'b1;
      end
      if (ack_wait >= 0 && n_req == ack_wait) begin
        mack = 1'b1;
        mrd  = mem_f(maddr);
      end else begin
        mack = 1'b0;
        mrd  = $urandom;
      end
      n_req++;
    end else begin
      mack = 1'($urandom_range(0, 1));
      mrd  = $urandom;
    end
    prev_req = mreq;
  end

  task automatic check_resp(input bit side);
    exp_t        e;
    logic [31:0] rd;
    rd = side ? d_rd : i_data;
    if ((side && exp_d.size() == 0) || (!side && exp_i.size() == 0)) begin
      n_chk++;
      n_fail++;
      $display("FAIL spurious_ready: side %0d pulsed ready, required no ready", side);
      return;
    end
    if (side) e = exp_d.pop_front();
    else      e = exp_i.pop_front();
    chk("read_data", rd, e.rdata);
    chk("bus_error", bus_error, e.err);
    chk("acc_addr", cap_addr, e.addr);
    chk("acc_wr_mask", {cap_wr, cap_mask}, {e.wr, e.mask});
    chk("acc_wdata", cap_wd, e.wdata);
    chk("req_cycles", n_req, e.ncyc);
    chk("fields_stable", unstable, 1'b0);
    if (e.lat >= 0) chk("latency", cyc - e.issue, e.lat);
    order_q.push_back(side);
    ord_cyc.push_back(cyc);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (i_rdy || d_rdy) chk("ready_exclusive", i_rdy & d_rdy, 1'b0);
      else                chk("bus_error_idle", bus_error, 1'b0);
      if (i_rdy) check_resp(1'b0);
      if (d_rdy) check_resp(1'b1);
    end
  end

  task automatic start_req(input bit side, input bit wr, input logic [31:0] a,
                           input logic [3:0] m, input logic [31:0] wd, input bit lat_ok);
    exp_t e;
    e.wr    = wr;
    e.addr  = a;
    e.mask  = m;
    e.wdata = side ? wd : 32'h0;
    e.err   = (ack_wait < 0) || (ack_wait >= TO);
    e.ncyc  = e.err ? TO : ack_wait + 1;
    if (!wr) model_rd[side] = e.err ? 32'h0 : mem_f(a);
    e.rdata = model_rd[side];
    e.lat   = lat_ok ? e.ncyc + 1 : -1;
    e.issue = cyc;
    if (side) begin
      d_st = wr; d_addr = a; d_mask = m; d_wd = wd; d_en = 1'b1;
      exp_d.push_back(e);
    end else begin
      i_st = wr; i_addr = a; i_mask = m; i_en = 1'b1;
      exp_i.push_back(e);
    end
  endtask

  task automatic rand_req(input bit side, input bit lat_ok);
    start_req(side, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, lat_ok);
  endtask

  task automatic wait_ready(input bit side);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = side ? d_rdy : i_rdy;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: side %0d saw no ready in 100 cycles, required one", side);
    end
  endtask

  task automatic drop(input bit side);
    @(posedge clk);
    #1;
    if (side) d_en = 1'b0;
    else      i_en = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_ctl", {mreq, mwr, mmask, i_rdy, d_rdy, bus_error}, '0);
    chk("rst_addr", maddr, '0);
    chk("rst_wdata", mwd, '0);
    chk("rst_idata", i_data, '0);
    chk("rst_ddata", d_rd, '0);
  endtask

  initial begin
    reset = 1'b0;
    i_en = 1'b0; i_st = 1'b0; i_addr = '0; i_mask = '0;
    d_en = 1'b0; d_st = 1'b0; d_addr = '0; d_mask = '0; d_wd = '0;
    mack = 1'b0; mrd = '0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b1;

    // Continuous contention from reset: I first, strict alternation, one access per 3 cycles.
    ack_wait = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          rand_req(1'b0, 1'b0);
          wait_ready(1'b0);
          @(posedge clk);
          #1;
        end
        i_en = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) begin
          rand_req(1'b1, 1'b0);
          wait_ready(1'b1);
          @(posedge clk);
          #1;
        end
        d_en = 1'b0;
      end
    join
    chk("order_len", order_q.size(), 8);
    for (int i = 0; i < order_q.size(); i++) chk("grant_order", order_q[i], i % 2);
    for (int i = 1; i < ord_cyc.size(); i++) chk("grant_spacing", ord_cyc[i] - ord_cyc[i-1], 3);

    // Zero-wait instruction read.
    ack_wait = 0;
    start_req(1'b0, 1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b1);
    wait_ready(1'b0);
    drop(1'b0);

    // Data write with 3 wait states: acknowledge lands on the timeout cycle and wins.
    ack_wait = 3;
    start_req(1'b1, 1'b1, 32'h0000_0100, 4'b0011, 32'hCAFE_F00D, 1'b1);
    wait_ready(1'b1);
    drop(1'b1);

    // Never-acknowledged data read aborts, then a normal read follows.
    ack_wait = -1;
    start_req(1'b1, 1'b0, 32'h0000_0200, 4'hF, 32'h1234_5678, 1'b1);
    wait_ready(1'b1);
    drop(1'b1);
    ack_wait = 1;
    start_req(1'b1, 1'b0, 32'h0000_0204, 4'hF, 32'h0, 1'b1);
    wait_ready(1'b1);
    drop(1'b1);

    // Reset during BUSY: access abandoned, held enable completes after release.
    ack_wait = 2;
    start_req(1'b0, 1'b0, 32'h0000_0040, 4'hF, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    chk("busy_request", mreq, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_rd[1] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_ready(1'b0);
    drop(1'b0);

    // Enable dropped and address changed right after the grant.
    ack_wait = 2;
    start_req(1'b0, 1'b0, 32'h0000_0080, 4'hF, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    i_en   = 1'b0;
    i_addr = 32'hDEAD_0000;
    wait_ready(1'b0);
    drop(1'b0);

    // Randomised single and contended traffic with random wait states, including aborts.
    for (int it = 0; it < 40; it++) begin
      int mode;
      mode     = $urandom_range(0, 2);
      ack_wait = $urandom_range(0, 5);
      if (ack_wait == 5) ack_wait = -1;
      if (mode < 2) begin
        rand_req(mode[0], 1'b1);
        wait_ready(mode[0]);
        drop(mode[0]);
      end else begin
        fork
          begin rand_req(1'b0, 1'b0); wait_ready(1'b0); drop(1'b0); end
          begin rand_req(1'b1, 1'b0); wait_ready(1'b1); drop(1'b1); end
        join
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queues_drained", exp_i.size() + exp_d.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
